// File: rtl/padded_window_reader.sv
// Captures one triple of zero-bordered RGB rows and streams stride-1 3x3 windows
// (left to right, one per accepted handshake), then pulses done for one cycle.
module padded_window_reader #(
  parameter int COLS  = 418,
  parameter int PIX_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rows_valid,
  output logic                   rows_ready,
  input  logic [COLS*PIX_W-1:0]  R_row0,
  input  logic [COLS*PIX_W-1:0]  R_row1,
  input  logic [COLS*PIX_W-1:0]  R_row2,
  input  logic [COLS*PIX_W-1:0]  G_row0,
  input  logic [COLS*PIX_W-1:0]  G_row1,
  input  logic [COLS*PIX_W-1:0]  G_row2,
  input  logic [COLS*PIX_W-1:0]  B_row0,
  input  logic [COLS*PIX_W-1:0]  B_row1,
  input  logic [COLS*PIX_W-1:0]  B_row2,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [9*PIX_W-1:0]     win_r,
  output logic [9*PIX_W-1:0]     win_g,
  output logic [9*PIX_W-1:0]     win_b,
  output logic [8:0]             win_col,
  output logic                   win_last,
  output logic                   done,
  output logic [1:0]             dbg_state_o
);

  localparam int ROW_W = COLS * PIX_W;
  localparam int WIN_W = 9 * PIX_W;
  localparam logic [8:0] LAST_COL = 9'(COLS - 3);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a window stays on win_* unchanged until it is accepted.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [8:0]           col_q, col_d;
  logic [ROW_W-1:0]     cap_q [9];
  logic [ROW_W-1:0]     cap_d [9];
  logic [ROW_W-1:0]     in_rows [9];
  logic [ROW_W-1:0]     src_rows [9];
  logic [8:0]           src_col;
  logic                 load_win;
  logic [WIN_W-1:0]     win_r_q, win_g_q, win_b_q;
  logic [WIN_W-1:0]     nxt_r, nxt_g, nxt_b;

  // Array order: R rows 0..2, G rows 0..2, B rows 0..2.
  assign in_rows[0] = R_row0;
  assign in_rows[1] = R_row1;
  assign in_rows[2] = R_row2;
  assign in_rows[3] = G_row0;
  assign in_rows[4] = G_row1;
  assign in_rows[5] = G_row2;
  assign in_rows[6] = B_row0;
  assign in_rows[7] = B_row1;
  assign in_rows[8] = B_row2;

  function automatic logic [WIN_W-1:0] build_win(
    input logic [ROW_W-1:0] r0,
    input logic [ROW_W-1:0] r1,
    input logic [ROW_W-1:0] r2,
    input logic [8:0]       c
  );
    logic [ROW_W-1:0] rows [3];
    logic [WIN_W-1:0] w;
    rows[0] = r0;
    rows[1] = r1;
    rows[2] = r2;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        w[(9 - (r * 3 + k)) * PIX_W - 1 -: PIX_W] =
          rows[r][(COLS - (int'(c) + k)) * PIX_W - 1 -: PIX_W];
      end
    end
    return w;
  endfunction

  // A fresh capture builds window 0 straight from the inputs; while streaming the
  // next window comes from the captured rows. Column is clamped on the last window
  // so the slice never runs off the row.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      src_rows[i] = (state_q == S_IDLE) ? in_rows[i] : cap_q[i];
    end
    if (state_q == S_IDLE) begin
      src_col = '0;
    end else if (col_q == LAST_COL) begin
      src_col = col_q;
    end else begin
      src_col = col_q + 9'd1;
    end
    nxt_r = build_win(src_rows[0], src_rows[1], src_rows[2], src_col);
    nxt_g = build_win(src_rows[3], src_rows[4], src_rows[5], src_col);
    nxt_b = build_win(src_rows[6], src_rows[7], src_rows[8], src_col);
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    load_win = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cap_d[i] = cap_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (rows_valid) begin
          for (int i = 0; i < 9; i++) begin
            cap_d[i] = in_rows[i];
          end
          col_d    = '0;
          load_win = 1'b1;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (win_ready) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = S_DONE;
          end else begin
            col_d    = col_q + 9'd1;
            load_win = 1'b1;
          end
        end
      end
      S_DONE: begin
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        col_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      win_r_q <= '0;
      win_g_q <= '0;
      win_b_q <= '0;
      for (int i = 0; i < 9; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      for (int i = 0; i < 9; i++) begin
        cap_q[i] <= cap_d[i];
      end
      if (load_win) begin
        win_r_q <= nxt_r;
        win_g_q <= nxt_g;
        win_b_q <= nxt_b;
      end
    end
  end

  assign rows_ready  = (state_q == S_IDLE) && !reset;
  assign win_valid   = (state_q == S_STREAM);
  assign win_last    = (state_q == S_STREAM) && (col_q == LAST_COL);
  assign done        = (state_q == S_DONE);
  assign win_col     = col_q;
  assign win_r       = win_r_q;
  assign win_g       = win_g_q;
  assign win_b       = win_b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_padded_window_reader.sv
// Directed bench for padded_window_reader: reset, ramp and border streams,
// backpressure, reset abort and back-to-back captures against a pixel model.
module tb_padded_window_reader;

  localparam int COLS  = 418;
  localparam int PIX_W = 8;
  localparam int ROW_W = COLS * PIX_W;
  localparam int NWIN  = COLS - 2;
  localparam int EXP_W = 9 + 1 + 3 * 9 * PIX_W;

  logic               clk;
  logic               reset;
  logic               rows_valid;
  logic               rows_ready;
  logic [ROW_W-1:0]   r_rows [3];
  logic [ROW_W-1:0]   g_rows [3];
  logic [ROW_W-1:0]   b_rows [3];
  logic               win_valid;
  logic               win_ready;
  logic [9*PIX_W-1:0] win_r, win_g, win_b;
  logic [8:0]         win_col;
  logic               win_last;
  logic               done;
  logic [1:0]         dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [EXP_W-1:0]   exp_q[$];
  logic [9*PIX_W-1:0] last_win_r;

  padded_window_reader #(.COLS(COLS), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset),
    .rows_valid(rows_valid), .rows_ready(rows_ready),
    .R_row0(r_rows[0]), .R_row1(r_rows[1]), .R_row2(r_rows[2]),
    .G_row0(g_rows[0]), .G_row1(g_rows[1]), .G_row2(g_rows[2]),
    .B_row0(b_rows[0]), .B_row1(b_rows[1]), .B_row2(b_rows[2]),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_r(win_r), .win_g(win_g), .win_b(win_b),
    .win_col(win_col), .win_last(win_last), .done(done),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel model: pattern, channel (0=R,1=G,2=B), row, column.
  function automatic logic [7:0] pix(input int pat, input int ch, input int r, input int c);
    case (pat)
      0:       return 8'((r * 3 + c) & 255);
      1:       return (c == 0 || c == COLS - 1) ? 8'h00 : 8'hFF;
      2:       return 8'((r * 7 + c * 3 + ch * 50 + 11) & 255);
      default: return 8'((c * 5 + r * 13 + ch * 29 + 100) & 255);
    endcase
  endfunction

  function automatic logic [9*PIX_W-1:0] exp_win(input int pat, input int ch, input int c);
    logic [9*PIX_W-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        w[(9 - (r * 3 + k)) * PIX_W - 1 -: PIX_W] = pix(pat, ch, r, c + k);
      end
    end
    return w;
  endfunction

  // Driver tasks
  task automatic load_rows(input int pat);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < COLS; c++) begin
        r_rows[r][(COLS - c) * PIX_W - 1 -: PIX_W] = pix(pat, 0, r, c);
        g_rows[r][(COLS - c) * PIX_W - 1 -: PIX_W] = pix(pat, 1, r, c);
        b_rows[r][(COLS - c) * PIX_W - 1 -: PIX_W] = pix(pat, 2, r, c);
      end
    end
  endtask

  task automatic fill_queue(input int pat);
    for (int c = 0; c < NWIN; c++) begin
      exp_q.push_back({9'(c), (c == NWIN - 1), exp_win(pat, 0, c), exp_win(pat, 1, c),
                       exp_win(pat, 2, c)});
    end
  endtask

  task automatic start_capture(input int pat, input logic hold);
    load_rows(pat);
    fill_queue(pat);
    rows_valid = 1'b1;
    n_cmp++;
    if (rows_ready !== 1'b1) begin
      n_err++;
      $display("FAIL capture_rows_ready: got %b want 1", rows_ready);
    end
    tick();
    rows_valid = hold;
  endtask

  // Scoreboard: every visible window is compared with the queue head, popped on accept.
  task automatic run_stream(input logic bp);
    int acc = 0;
    int cyc = 0;
    logic [EXP_W-1:0] obs, prev, want;
    logic hold = 1'b0;
    logic rdy, v;
    while (acc < NWIN && cyc < 4 * NWIN) begin
      obs = {win_col, win_last, win_r, win_g, win_b};
      v = win_valid;
      n_cmp++;
      if (v !== 1'b1) begin
        n_err++;
        $display("FAIL stream_valid: col %0d got %b want 1", acc, v);
      end
      if (hold) begin
        n_cmp++;
        if (obs !== prev) begin
          n_err++;
          $display("FAIL stall_hold: got %h want %h", obs, prev);
        end
      end
      want = (exp_q.size() > 0) ? exp_q[0] : '1;
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL window: idx %0d got %h want %h", acc, obs, want);
      end
      if (acc == NWIN - 1) last_win_r = win_r;
      rdy = bp ? (cyc % 2 == 0) : 1'b1;
      win_ready = rdy;
      prev = obs;
      hold = !rdy;
      tick();
      cyc++;
      if (rdy && v === 1'b1) begin
        acc++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    win_ready = 1'b0;
    n_cmp++;
    if (acc != NWIN) begin
      n_err++;
      $display("FAIL stream_count: got %0d want %0d", acc, NWIN);
    end
    n_cmp++;
    if ({done, win_valid, rows_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL done_cycle: got done/valid/rdy %b%b%b want 100", done, win_valid, rows_ready);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained: got %0d left want 0", exp_q.size());
    end
    tick();
    n_cmp++;
    if ({done, win_valid, rows_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL after_done: got done/valid/rdy %b%b%b want 001", done, win_valid, rows_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({win_valid, win_last, done, rows_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b%b%b%b want 0000", win_valid, win_last, done, rows_ready);
    end
    n_cmp++;
    if ({win_r, win_g, win_b, win_col} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got r=%h col=%0d want 0", win_r, win_col);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({rows_ready, win_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: got rdy/valid %b%b want 10", rows_ready, win_valid);
    end
  endtask

  task automatic test_ramp();
    start_capture(0, 1'b0);
    n_cmp++;
    if (win_r !== 72'h000102030405060708 || win_col !== 9'd0) begin
      n_err++;
      $display("FAIL ramp_win0: got r=%h col=%0d want 000102030405060708 col 0", win_r, win_col);
    end
    run_stream(1'b0);
  endtask

  task automatic test_border();
    start_capture(1, 1'b0);
    n_cmp++;
    if (win_r !== 72'h00FFFF00FFFF00FFFF) begin
      n_err++;
      $display("FAIL border_win0: got %h want 00FFFF00FFFF00FFFF", win_r);
    end
    run_stream(1'b0);
    n_cmp++;
    if (last_win_r !== 72'hFFFF00FFFF00FFFF00) begin
      n_err++;
      $display("FAIL border_win415: got %h want FFFF00FFFF00FFFF00", last_win_r);
    end
  endtask

  task automatic test_backpressure();
    start_capture(2, 1'b0);
    run_stream(1'b1);
  endtask

  task automatic test_reset_mid_stream();
    int cyc = 0;
    logic saw_done = 1'b0;
    start_capture(3, 1'b0);
    win_ready = 1'b1;
    while (win_col !== 9'd100 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (win_col !== 9'd100) begin
      n_err++;
      $display("FAIL abort_reach_col: got %0d want 100", win_col);
    end
    reset = 1'b1;
    win_ready = 1'b0;
    tick();
    n_cmp++;
    if ({win_valid, done, win_col} !== 11'd0 || win_r !== '0) begin
      n_err++;
      $display("FAIL abort_state: got valid %b done %b col %0d want 0", win_valid, done, win_col);
    end
    reset = 1'b0;
    exp_q.delete();
    tick();
    n_cmp++;
    if ({rows_ready, win_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_release: got rdy/valid %b%b want 10", rows_ready, win_valid);
    end
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got done pulse want none");
    end
    start_capture(2, 1'b0);
    n_cmp++;
    if (win_col !== 9'd0 || win_valid !== 1'b1) begin
      n_err++;
      $display("FAIL restart_col: got col %0d valid %b want 0 1", win_col, win_valid);
    end
    run_stream(1'b0);
  endtask

  task automatic test_back_to_back();
    start_capture(2, 1'b1);
    load_rows(3);
    run_stream(1'b0);
    fill_queue(3);
    tick();
    rows_valid = 1'b0;
    n_cmp++;
    if (win_valid !== 1'b1 || win_col !== 9'd0) begin
      n_err++;
      $display("FAIL b2b_capture: got valid %b col %0d want 1 0", win_valid, win_col);
    end
    run_stream(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    rows_valid = 1'b0;
    win_ready  = 1'b0;
    last_win_r = '0;
    for (int r = 0; r < 3; r++) begin
      r_rows[r] = '0;
      g_rows[r] = '0;
      b_rows[r] = '0;
    end
    test_reset();
    test_ramp();
    test_border();
    test_backpressure();
    test_reset_mid_stream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
